// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel timing from an external active-low
// hsync/vsync pair. It regenerates column/row coordinates and measures line
// and frame periods. A SEARCH/TRACK/LOCKED state machine decides when the
// timing is trustworthy.
// Optional feature macro: VGA_RX_INSYNC_EN. It inserts a 2-flop synchronizer
// on hsync/vsync for asynchronous sources, which adds 2 cycles of latency.
module vga_sync_receiver #(
  parameter int unsigned H_VISIBLE    = 800,
  parameter int unsigned H_TOTAL      = 1056,
  parameter int unsigned H_SYNC_START = 841,
  parameter int unsigned V_VISIBLE    = 600,
  parameter int unsigned V_TOTAL      = 628,
  parameter int unsigned V_SYNC_START = 602,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic [15:0] column,
  output logic [15:0] row,
  output logic        activeDisplayRegion,
  output logic        locked,
  output logic        lock_err,
  output logic [15:0] line_len,
  output logic [15:0] frame_lines
);

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_LEN    = 16'(H_TOTAL);
  localparam logic [15:0] V_LEN    = 16'(V_TOTAL);
  localparam logic [15:0] H_LOSS   = 16'(2 * H_TOTAL);
  localparam logic [4:0]  LOCK_CNT = 5'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  // Bit 0 carries hsync and bit 1 carries vsync through the same front end.
  logic [1:0] sync_raw;
  logic [1:0] sync_in;
  logic [1:0] sync_q_reg;
  logic [1:0] sync_fall;

  assign sync_raw = {vsync, hsync};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
`ifdef VGA_RX_INSYNC_EN
      logic [1:0] meta_reg;
      // Two-flop synchronizer for an asynchronous sync source
      always_ff @(posedge clk) begin
        if (reset) meta_reg <= 2'b00;
        else       meta_reg <= {meta_reg[0], sync_raw[gi]};
      end
      assign sync_in[gi] = meta_reg[1];
`else
      assign sync_in[gi] = sync_raw[gi];
`endif
      // Previous-sample register for falling-edge detection
      always_ff @(posedge clk) begin
        if (reset) sync_q_reg[gi] <= 1'b0;
        else       sync_q_reg[gi] <= sync_in[gi];
      end
      assign sync_fall[gi] = !sync_in[gi] && sync_q_reg[gi];
    end
  endgenerate

  logic hfall, vfall;
  assign hfall = sync_fall[0];
  assign vfall = sync_fall[1];

  logic [15:0] column_reg, row_reg, h_cnt_reg, v_cnt_reg;
  logic [15:0] line_len_reg, frame_lines_reg;
  logic        h_valid_reg, line_bad_reg, lock_err_reg, locked_reg;
  state_t      state_reg, state_next;
  logic [3:0]  good_cnt_reg, good_cnt_next;
  logic        lock_err_next;

  logic [15:0] h_cnt_inc, v_cnt_now;
  logic        col_wrap, sync_loss, line_err, frame_good;

  assign h_cnt_inc  = h_cnt_reg + 16'd1;
  assign v_cnt_now  = v_cnt_reg + {15'd0, hfall};
  assign col_wrap   = !hfall && (column_reg == H_LAST);
  assign sync_loss  = (h_cnt_reg == H_LOSS);
  assign line_err   = hfall && h_valid_reg && (h_cnt_inc != H_LEN);
  // A coincident hfall still belongs to the frame that is ending.
  assign frame_good = (v_cnt_now == V_LEN) && !(line_bad_reg || line_err);

  // Coordinate counters, period measurement and sticky line error
  always_ff @(posedge clk) begin
    if (reset) begin
      column_reg      <= '0;
      row_reg         <= '0;
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      line_len_reg    <= '0;
      frame_lines_reg <= '0;
      h_valid_reg     <= 1'b0;
      line_bad_reg    <= 1'b0;
    end else begin
      if (hfall)         column_reg <= 16'(H_SYNC_START);
      else if (col_wrap) column_reg <= '0;
      else               column_reg <= column_reg + 16'd1;

      if (vfall)         row_reg <= 16'(V_SYNC_START);
      else if (col_wrap) row_reg <= (row_reg == V_LAST) ? 16'd0 : row_reg + 16'd1;

      if (hfall) begin
        h_cnt_reg    <= '0;
        line_len_reg <= h_cnt_inc;
      end else if (h_cnt_reg != 16'hFFFF) begin
        h_cnt_reg <= h_cnt_inc;
      end

      if (sync_loss)  h_valid_reg <= 1'b0;
      else if (hfall) h_valid_reg <= 1'b1;

      if (vfall) begin
        v_cnt_reg       <= '0;
        frame_lines_reg <= v_cnt_now;
        line_bad_reg    <= 1'b0;
      end else begin
        v_cnt_reg <= v_cnt_now;
        if (line_err) line_bad_reg <= 1'b1;
      end
    end
  end

  // Lock state register and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= SEARCH;
      good_cnt_reg <= '0;
      locked_reg   <= 1'b0;
      lock_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      locked_reg   <= (state_next == LOCKED);
      lock_err_reg <= lock_err_next;
    end
  end

  // Next-state logic; a missing hsync overrides everything
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    if (sync_loss) begin
      state_next    = SEARCH;
      good_cnt_next = '0;
    end else begin
      case (state_reg)
        SEARCH: begin
          if (vfall) begin
            state_next    = TRACK;
            good_cnt_next = '0;
          end
        end
        TRACK: begin
          if (vfall) begin
            if (frame_good) begin
              good_cnt_next = good_cnt_reg + 4'd1;
              if (({1'b0, good_cnt_reg} + 5'd1) == LOCK_CNT) state_next = LOCKED;
            end else begin
              good_cnt_next = '0;
            end
          end
        end
        LOCKED: begin
          if (line_err || (vfall && !frame_good)) begin
            state_next    = TRACK;
            good_cnt_next = '0;
          end
        end
        default: begin
          state_next    = SEARCH;
          good_cnt_next = '0;
        end
      endcase
    end
  end

  // Output logic: flag every exit from LOCKED
  always_comb begin
    lock_err_next = (state_reg == LOCKED) && (state_next != LOCKED);
  end

  assign column              = column_reg;
  assign row                 = row_reg;
  assign line_len            = line_len_reg;
  assign frame_lines         = frame_lines_reg;
  assign locked              = locked_reg;
  assign lock_err            = lock_err_reg;
  assign activeDisplayRegion = (column_reg < 16'(H_VISIBLE)) &&
                               (row_reg < 16'(V_VISIBLE)) && locked_reg;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a scaled-down raster
// (24 clocks x 12 lines) so that many frames fit in a short run.
module tb_vga_sync_receiver;

  localparam int HV  = 16;
  localparam int HT  = 24;
  localparam int HSS = 18;
  localparam int VV  = 8;
  localparam int VT  = 12;
  localparam int VSS = 9;
  localparam int LF  = 2;
  localparam int HS_W = 4;   // hsync low clocks per line
  localparam int VS_W = 2;   // vsync low lines per frame
`ifdef VGA_RX_INSYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int M_NONE = 0, M_UNLOCKED = 1, M_LOCK_RISE = 2, M_ALIGN = 3,
                 M_GLITCH = 4, M_RESET = 5, M_SHORT = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [15:0] column, row, line_len, frame_lines;
  logic        activeDisplayRegion, locked, lock_err;

  int n_checks = 0;
  int n_pass = 0;
  int lock_err_seen = 0;

  vga_sync_receiver #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS),
    .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC_START(VSS),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .column(column), .row(row), .activeDisplayRegion(activeDisplayRegion),
    .locked(locked), .lock_err(lock_err),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lock_err === 1'b1) lock_err_seen <= lock_err_seen + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    $display("check %-16s got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input logic h, input logic v);
    @(negedge clk);
    hsync = h;
    vsync = v;
  endtask

  // Remainder of a frame after the sync edge cycle already driven
  task automatic drive_rest(input int nlines, input int stretch);
    int len;
    for (int l = 0; l < nlines; l++) begin
      len = (l == stretch) ? HT + 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (!(l == 0 && c == 0)) tick((c < HS_W) ? 1'b0 : 1'b1, (l < VS_W) ? 1'b0 : 1'b1);
      end
    end
  endtask

  // Checks timed from the first sample after the frame's sync edge
  task automatic frame_checks(input int mode);
    repeat (LAT) @(posedge clk);
    #1;
    case (mode)
      M_UNLOCKED: check("unlocked", locked, 0);
      M_LOCK_RISE: begin
        check("lock_rise", locked, 1);
        check("lock_err_idle", lock_err, 0);
        check("frame_lines", frame_lines, VT);
        check("line_len", line_len, HT);
      end
      M_ALIGN: begin
        check("col_at_edge", column, HSS);
        check("row_at_edge", row, VSS);
        repeat (6) @(posedge clk);
        #1;
        check("col_wrap0", column, 0);
        check("row_after_wrap", row, VSS + 1);
        repeat (48) @(posedge clk);
        #1;
        check("origin_row", row, 0);
        check("origin_col", column, 0);
        check("active_origin", activeDisplayRegion, 1);
        repeat (15) @(posedge clk);
        #1;
        check("active_lastcol", activeDisplayRegion, 1);
        @(posedge clk);
        #1;
        check("col_visible_end", column, HV);
        check("active_off", activeDisplayRegion, 0);
      end
      M_GLITCH: begin
        repeat (5 * HT + HT + 1) @(posedge clk);
        #1;
        check("glitch_line_len", line_len, HT + 1);
        check("glitch_lock_err", lock_err, 1);
        check("glitch_unlock", locked, 0);
        @(posedge clk);
        #1;
        check("lock_err_pulse", lock_err, 0);
      end
      M_RESET: begin
        repeat (200) @(posedge clk);
        #1;
        check("pre_rst_row", row, 6);
        check("pre_rst_col", column, 2);
        check("pre_rst_locked", locked, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_col", column, 0);
        check("rst_row", row, 0);
        check("rst_active", activeDisplayRegion, 0);
        check("rst_locked", locked, 0);
        check("rst_lock_err", lock_err, 0);
        check("rst_line_len", line_len, 0);
        check("rst_frame_lines", frame_lines, 0);
        reset = 1'b0;
      end
      M_SHORT: begin
        check("short_frame", frame_lines, VT - 1);
        check("short_unlocked", locked, 0);
      end
      default: ;
    endcase
  endtask

  task automatic run_frame(input int nlines, input int stretch, input int mode);
    tick(1'b0, 1'b0);
    fork
      drive_rest(nlines, stretch);
      frame_checks(mode);
    join
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("init_col", column, 0);
    check("init_row", row, 0);
    check("init_active", activeDisplayRegion, 0);
    check("init_locked", locked, 0);
    check("init_lock_err", lock_err, 0);
    check("init_line_len", line_len, 0);
    check("init_frame_lines", frame_lines, 0);
    reset = 1'b0;
    repeat (5) tick(1'b1, 1'b1);

    // Initial lock: partial frame, then LF good frames
    run_frame(VT, -1, M_UNLOCKED);
    run_frame(VT, -1, M_UNLOCKED);
    check("pre_lock", locked, 0);
    check("pre_lock_frames", frame_lines, VT);
    check("pre_lock_line", line_len, HT);
    run_frame(VT, -1, M_LOCK_RISE);

    // Coordinate alignment while locked
    run_frame(VT, -1, M_ALIGN);

    // One stretched line drops lock; relock after 2 good frames
    run_frame(VT, 5, M_GLITCH);
    check("lock_err_count1", lock_err_seen, 1);
    run_frame(VT, -1, M_UNLOCKED);
    run_frame(VT, -1, M_UNLOCKED);
    run_frame(VT, -1, M_LOCK_RISE);

    // Missing hsync while locked
    repeat (20) tick(1'b1, 1'b1);
    check("loss_hold_locked", locked, 1);
    repeat (40) tick(1'b1, 1'b1);
    check("loss_unlocked", locked, 0);
    check("lock_err_count2", lock_err_seen, 2);
    run_frame(VT, -1, M_UNLOCKED);
    run_frame(VT, -1, M_UNLOCKED);
    run_frame(VT, -1, M_LOCK_RISE);

    // Reset mid-frame, then a short frame while tracking
    run_frame(VT, -1, M_RESET);
    run_frame(VT, -1, M_UNLOCKED);
    run_frame(VT - 1, -1, M_UNLOCKED);
    run_frame(VT, -1, M_SHORT);
    run_frame(VT, -1, M_UNLOCKED);
    run_frame(VT, -1, M_LOCK_RISE);
    check("lock_err_total", lock_err_seen, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Recovers pixel timing from an incoming active-low hsync/vsync pair (800x600 @ 60 Hz, 1056x628 total, 40 MHz pixel clock). It regenerates column/row coordinates and an active-region flag, measures line and frame periods, and runs a lock state machine. It is the receive-side counterpart of the display timing generator and is used for loopback checking and for slaving pixel logic to an external sync source.

## Interface
- H_VISIBLE, 800: visible columns per line
- H_TOTAL, 1056: expected clocks per line
- H_SYNC_START, 841: column value loaded on hsync falling edge
- V_VISIBLE, 600: visible rows per frame
- V_TOTAL, 628: expected lines per frame
- V_SYNC_START, 602: row value loaded on vsync falling edge
- LOCK_FRAMES, 2: consecutive good frames required to lock (1..15)
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hsync  in  1  active-low horizontal sync
- vsync  in  1  active-low vertical sync
- column  out  16  recovered column
- row  out  16  recovered row
- activeDisplayRegion  out  1  column<H_VISIBLE && row<V_VISIBLE && locked
- locked  out  1  timing locked
- lock_err  out  1  one-cycle pulse when leaving LOCKED
- line_len  out  16  last measured hsync period (clocks)
- frame_lines  out  16  last measured vsync period (lines)

## Operation
- Reset values: column=0, row=0, activeDisplayRegion=0, locked=0, lock_err=0, line_len=0, frame_lines=0, state SEARCH, all internal counters 0.
- Edge detect: hsync/vsync are sampled into hs_q/vs_q. hfall = !hsync && hs_q; vfall = !vsync && vs_q.
- Column: on hfall, column <= H_SYNC_START. Otherwise it wraps to 0 at H_TOTAL-1, else increments.
- Row: on vfall, row <= V_SYNC_START. This takes priority over a wrap increment in the same cycle. Otherwise, on column wrap, row wraps to 0 at V_TOTAL-1, else increments.
- Line measurement: h_cnt counts clocks since the last hfall and saturates at 16'hFFFF. On hfall, line_len <= h_cnt+1 and h_cnt <= 0. h_valid is set on the first hfall after reset or SEARCH entry. Only hfalls with h_valid already set are checked.
- Line error: a checked hfall with h_cnt+1 != H_TOTAL sets the sticky line_bad flag, which is cleared on each vfall.
- Frame measurement: v_cnt counts hfalls since the last vfall. An hfall coincident with vfall counts toward the ending frame. On vfall, frame_lines <= that count and v_cnt <= 0.
- A frame is good when frame_lines == V_TOTAL and line_bad is clear, including any error from a coincident hfall.
- FSM:
  - SEARCH: on vfall go to TRACK, good_cnt=0, line_bad cleared. This first partial frame is never judged.
  - TRACK: on vfall, a good frame increments good_cnt. When good_cnt reaches LOCK_FRAMES, go to LOCKED. A bad frame sets good_cnt=0 and stays in TRACK.
  - LOCKED: a line error or bad frame goes to TRACK, with good_cnt=0 and lock_err pulsed.
  - Any state: h_cnt reaching 2*H_TOTAL (missing hsync) goes to SEARCH, clears h_valid, and pulses lock_err if the block was LOCKED.
- locked = (state == LOCKED), registered.
- Counters keep freewheeling in every state. Only locked gates activeDisplayRegion.

## Timing
- Synchronizer macro off:
  - hsync falls in cycle N → hfall in cycle N → column == H_SYNC_START in cycle N+1.
  - Same rule for vsync/row.
- The locked, lock_err and line_len/frame_lines updates are visible the cycle after the deciding edge.
- activeDisplayRegion is combinational from the column, row and locked registers, so it has no extra latency.
- Reset asserted mid-frame returns the block to the reset values on the next edge. Relock then needs 1 partial frame plus LOCK_FRAMES good frames.
- All counts are unsigned 16-bit. Comparisons are exact, with no tolerance window.

## Configuration
- VGA_RX_INSYNC_EN:
  - Defined: hsync/vsync pass through a 2-flop synchronizer before edge detection. This adds 2 cycles to every edge-to-output latency (column == H_SYNC_START in cycle N+3). Used when the sync source is asynchronous.
  - Undefined: inputs feed edge detection directly.

## Test plan
- Lock: 800x600 stimulus with hsync low for 128 clocks, vsync low for 4 lines, LOCK_FRAMES=2 → locked rises the cycle after the 3rd vfall following reset; frame_lines=628; line_len=1056.
- Alignment (locked): hsync falls in cycle N → column=841 at N+1, then column 0 at N+216; row 0 and column 0 give activeDisplayRegion=1; column 800 gives 0.
- Line glitch: one line stretched to 1057 clocks while LOCKED → line_len=1057, lock_err pulses once, locked=0; relock after 2 further good frames.
- Sync loss: hold hsync high for 2112 clocks while LOCKED → state SEARCH, lock_err pulse, locked=0; resume stimulus → relock as in the lock test.
- Short frame: 627-line frame in TRACK → frame_lines=627, good_cnt reset, locked stays 0.
- Reset mid-frame at row 300 → all outputs 0 the next cycle; with VGA_RX_INSYNC_EN, the alignment test shows column=841 at N+3.
